// File: rtl/sprite_motion_engine.sv
// -----------------------------------------------------------------------------
// sprite_motion_engine
//   Position engine for one moving object (enemy / bouncing sprite) in the
//   640x480 arena. A private divider produces a motion tick every TICK_DIV
//   clocks; on each tick the sprite bounces off the player (axis-aligned box
//   overlap, reflect away with a saturating speed-up) and then off the arena
//   walls (reflect and clamp).
//
//   Build option: define SPRITE_HIT_COOLDOWN_EN to ignore player overlap for
//   COOLDOWN_TICKS ticks after each hit. Without it every overlapping tick is
//   a hit.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   gamemenu   menu state   (menu alone -> reload start values every clk)
//   gamerun    run state    (run alone  -> divider runs, motion updates)
//   gamepause  pause state  (any other mode combination freezes everything)
//   aX, aY     player centre
//   aR         player half-size
//   x, y       sprite centre
//   vx, vy     signed sprite velocity, W+1 bits
//   collide    one-clk pulse on a player hit
//   hit_count  hits since menu/reset, saturates at 255
// -----------------------------------------------------------------------------
module sprite_motion_engine #(
    parameter int W              = 10,
    parameter int X_INIT         = 160,
    parameter int Y_INIT         = 120,
    parameter int VX_INIT        = -20,
    parameter int VY_INIT        = -20,
    parameter int HALF           = 10,
    parameter int X_MIN          = 15,
    parameter int X_MAX          = 626,
    parameter int Y_MIN          = 15,
    parameter int Y_MAX          = 466,
    parameter int TICK_DIV       = 100000000,
    parameter int V_STEP         = 2,
    parameter int V_MAX          = 40,
    parameter int COOLDOWN_TICKS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                gamemenu,
    input  logic                gamerun,
    input  logic                gamepause,
    input  logic [W-1:0]        aX,
    input  logic [W-1:0]        aY,
    input  logic [W-1:0]        aR,
    output logic [W-1:0]        x,
    output logic [W-1:0]        y,
    output logic signed [W:0]   vx,
    output logic signed [W:0]   vy,
    output logic                collide,
    output logic [7:0]          hit_count
);

    // Three extra bits keep edge maths (x-HALF, aX+aR, ...) free of wrap.
    localparam int IW = W + 3;
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

`ifdef SPRITE_HIT_COOLDOWN_EN
    localparam bit CD_EN = 1'b1;
`else
    localparam bit CD_EN = 1'b0;
`endif
    // With the feature off the cooldown counter is only ever loaded with 0.
    localparam int CDW     = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;
    localparam int CD_LOAD = CD_EN ? COOLDOWN_TICKS : 0;

    localparam logic [W-1:0]         X0     = W'(X_INIT);
    localparam logic [W-1:0]         Y0     = W'(Y_INIT);
    localparam logic signed [W:0]    VX0    = (W+1)'(VX_INIT);
    localparam logic signed [W:0]    VY0    = (W+1)'(VY_INIT);
    localparam logic signed [IW-1:0] HALF_S = IW'(HALF);
    localparam logic signed [IW-1:0] XMIN_S = IW'(X_MIN);
    localparam logic signed [IW-1:0] XMAX_S = IW'(X_MAX);
    localparam logic signed [IW-1:0] YMIN_S = IW'(Y_MIN);
    localparam logic signed [IW-1:0] YMAX_S = IW'(Y_MAX);
    localparam logic signed [IW-1:0] STEP_S = IW'(V_STEP);
    localparam logic signed [IW-1:0] VMAX_S = IW'(V_MAX);

    function automatic logic signed [IW-1:0] absV(input logic signed [IW-1:0] v);
        return v[IW-1] ? -v : v;
    endfunction

    function automatic logic signed [IW-1:0] minS(input logic signed [IW-1:0] a,
                                                  input logic signed [IW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // Point the velocity away from the player; equal centres just flip it.
    function automatic logic signed [IW-1:0] reflect(input logic signed [IW-1:0] v,
                                                     input logic signed [IW-1:0] s,
                                                     input logic signed [IW-1:0] p);
        if (s > p)      return absV(v);
        else if (s < p) return -absV(v);
        else            return -v;
    endfunction

    function automatic logic signed [IW-1:0] speedUp(input logic signed [IW-1:0] v);
        logic signed [IW-1:0] mag;
        if (v == '0) return '0;
        mag = absV(v) + STEP_S;
        if (mag > VMAX_S) mag = VMAX_S;
        return v[IW-1] ? -mag : mag;
    endfunction

    logic [CW-1:0]         tickCnt;
    logic [CDW-1:0]        coolCnt;
    logic                  isMenu, isRun;
    logic                  overlapX, overlapY, hit, reflX, reflY;
    logic signed [IW-1:0]  sx, sy, px, py, pr, vxE, vyE;
    logic signed [IW-1:0]  penX, penY, vxR, vyR, vxS, vyS, nx, ny;
    logic signed [IW-1:0]  xNext, yNext, vxNext, vyNext;

    assign isMenu = gamemenu & ~gamerun & ~gamepause;
    assign isRun  = ~gamemenu & gamerun & ~gamepause;

    always_comb begin
        sx  = $signed({3'b000, x});
        sy  = $signed({3'b000, y});
        px  = $signed({3'b000, aX});
        py  = $signed({3'b000, aY});
        pr  = $signed({3'b000, aR});
        vxE = {{2{vx[W]}}, vx};
        vyE = {{2{vy[W]}}, vy};

        // Strict overlap: boxes that only touch are not a hit.
        overlapX = (px - pr < sx + HALF_S) && (sx - HALF_S < px + pr);
        overlapY = (py - pr < sy + HALF_S) && (sy - HALF_S < py + pr);
        hit      = overlapX && overlapY && (coolCnt == '0);

        penX  = minS(px + pr - (sx - HALF_S), sx + HALF_S - (px - pr));
        penY  = minS(py + pr - (sy - HALF_S), sy + HALF_S - (py - pr));
        reflX = hit && (penX <= penY);
        reflY = hit && (penY <= penX);

        vxR = reflX ? reflect(vxE, sx, px) : vxE;
        vyR = reflY ? reflect(vyE, sy, py) : vyE;
        vxS = hit ? speedUp(vxR) : vxR;
        vyS = hit ? speedUp(vyR) : vyR;

        nx = sx + vxS;
        if (nx - HALF_S < XMIN_S) begin
            xNext  = XMIN_S + HALF_S;
            vxNext = absV(vxS);
        end else if (nx + HALF_S > XMAX_S) begin
            xNext  = XMAX_S - HALF_S;
            vxNext = -absV(vxS);
        end else begin
            xNext  = nx;
            vxNext = vxS;
        end

        ny = sy + vyS;
        if (ny - HALF_S < YMIN_S) begin
            yNext  = YMIN_S + HALF_S;
            vyNext = absV(vyS);
        end else if (ny + HALF_S > YMAX_S) begin
            yNext  = YMAX_S - HALF_S;
            vyNext = -absV(vyS);
        end else begin
            yNext  = ny;
            vyNext = vyS;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || isMenu) begin
            x         <= X0;
            y         <= Y0;
            vx        <= VX0;
            vy        <= VY0;
            tickCnt   <= '0;
            coolCnt   <= '0;
            collide   <= 1'b0;
            hit_count <= 8'd0;
        end else if (isRun) begin
            if (tickCnt == TICK_LAST) begin
                tickCnt <= '0;
                x       <= xNext[W-1:0];
                y       <= yNext[W-1:0];
                vx      <= vxNext[W:0];
                vy      <= vyNext[W:0];
                collide <= hit;
                if (hit && hit_count != 8'hFF)
                    hit_count <= hit_count + 8'd1;
                if (hit)
                    coolCnt <= CDW'(CD_LOAD);
                else if (coolCnt != '0)
                    coolCnt <= coolCnt - 1'b1;
            end else begin
                tickCnt <= tickCnt + 1'b1;
                collide <= 1'b0;
            end
        end else begin
            collide <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sprite_motion_engine.sv
module tb_sprite_motion_engine;

    localparam int TDIV  = 4;
    localparam int HALF  = 10;
    localparam int XMIN  = 15;
    localparam int XMAX  = 626;
    localparam int YMIN  = 15;
    localparam int YMAX  = 466;
    localparam int VSTEP = 2;
    localparam int VMAX  = 40;
    localparam int CDT   = 3;

    logic              clk;
    logic              rst, gamemenu, gamerun, gamepause;
    logic [9:0]        aX, aY, aR;
    logic [9:0]        x, y;
    logic signed [10:0] vx, vy;
    logic              collide;
    logic [7:0]        hit_count;

    int errCnt = 0;
    int chkCnt = 0;

    // reference model state
    int mX, mY, mVx, mVy, mCol, mHits, mTick, mCd;

    sprite_motion_engine #(.TICK_DIV(TDIV)) dut (
        .clk(clk), .rst(rst),
        .gamemenu(gamemenu), .gamerun(gamerun), .gamepause(gamepause),
        .aX(aX), .aY(aY), .aR(aR),
        .x(x), .y(y), .vx(vx), .vy(vy),
        .collide(collide), .hit_count(hit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input int obs, input int exp);
        chkCnt++;
        if (obs != exp) begin
            errCnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int awayFrom(input int v, input int s, input int p);
        if (s > p) return iabs(v);
        if (s < p) return -iabs(v);
        return -v;
    endfunction

    function automatic int faster(input int v);
        int m;
        if (v == 0) return 0;
        m = imin(iabs(v) + VSTEP, VMAX);
        return (v < 0) ? -m : m;
    endfunction

    task automatic modelReset();
        mX = 160; mY = 120; mVx = -20; mVy = -20;
        mCol = 0; mHits = 0; mTick = 0; mCd = 0;
    endtask

    // One motion update, straight from the movement rules.
    task automatic modelTick();
        int ax, ay, ar, penX, penY, nx, ny;
        bit ovl, hit;
        ax = aX; ay = aY; ar = aR;
        ovl = (ax - ar < mX + HALF) && (mX - HALF < ax + ar) &&
              (ay - ar < mY + HALF) && (mY - HALF < ay + ar);
`ifdef SPRITE_HIT_COOLDOWN_EN
        if (mCd > 0) begin
            mCd--;
            hit = 0;
        end else begin
            hit = ovl;
            if (hit) mCd = CDT;
        end
`else
        hit = ovl;
`endif
        if (hit) begin
            penX = imin(ax + ar - (mX - HALF), mX + HALF - (ax - ar));
            penY = imin(ay + ar - (mY - HALF), mY + HALF - (ay - ar));
            if (penX <= penY) mVx = awayFrom(mVx, mX, ax);
            if (penY <= penX) mVy = awayFrom(mVy, mY, ay);
            mVx = faster(mVx);
            mVy = faster(mVy);
            if (mHits < 255) mHits++;
        end
        nx = mX + mVx;
        if (nx - HALF < XMIN)      begin mX = XMIN + HALF; mVx = iabs(mVx);  end
        else if (nx + HALF > XMAX) begin mX = XMAX - HALF; mVx = -iabs(mVx); end
        else                       mX = nx;
        ny = mY + mVy;
        if (ny - HALF < YMIN)      begin mY = YMIN + HALF; mVy = iabs(mVy);  end
        else if (ny + HALF > YMAX) begin mY = YMAX - HALF; mVy = -iabs(mVy); end
        else                       mY = ny;
        mCol = hit;
    endtask

    task automatic modelStep();
        if (rst || (gamemenu && !gamerun && !gamepause)) begin
            modelReset();
        end else if (!gamemenu && gamerun && !gamepause) begin
            if (mTick == TDIV - 1) begin
                mTick = 0;
                modelTick();
            end else begin
                mTick++;
                mCol = 0;
            end
        end else begin
            mCol = 0;
        end
    endtask

    task automatic checkAll();
        checkVal("x", x, mX);
        checkVal("y", y, mY);
        checkVal("vx", vx, mVx);
        checkVal("vy", vy, mVy);
        checkVal("collide", collide, mCol);
        checkVal("hit_count", hit_count, mHits);
    endtask

    task automatic runClks(input int n);
        repeat (n) begin
            @(posedge clk);
            modelStep();
            #1;
            checkAll();
        end
    endtask

    task automatic setPlayer(input int px, input int py, input int pr);
        aX = 10'(px); aY = 10'(py); aR = 10'(pr);
    endtask

    task automatic restartRun(input int px, input int py, input int pr);
        setPlayer(px, py, pr);
        rst = 1; gamemenu = 0; gamerun = 1; gamepause = 0;
        runClks(1);
        rst = 0;
    endtask

    initial begin
        int t, sel;
        rst = 1; gamemenu = 0; gamerun = 0; gamepause = 0;
        setPlayer(600, 400, 5);

        // reset values
        runClks(1);
        checkVal("rst_x", x, 160);
        checkVal("rst_y", y, 120);
        checkVal("rst_vx", vx, -20);
        checkVal("rst_vy", vy, -20);
        checkVal("rst_collide", collide, 0);
        checkVal("rst_hits", hit_count, 0);

        // free flight: update lands on the 4th RUN clock
        rst = 0; gamerun = 1;
        runClks(3);
        checkVal("pre_tick_x", x, 160);
        runClks(1);
        checkVal("tick1_x", x, 140);
        checkVal("tick1_y", y, 100);
        checkVal("tick1_collide", collide, 0);

        // x-penetration smaller: only vx reflects, both components speed up
        restartRun(145, 120, 10);
        runClks(4);
        checkVal("hit_x", x, 182);
        checkVal("hit_y", y, 98);
        checkVal("hit_vx", vx, 22);
        checkVal("hit_vy", vy, -22);
        checkVal("hit_collide", collide, 1);
        checkVal("hit_count1", hit_count, 1);
        runClks(1);
        checkVal("hit_pulse_end", collide, 0);

        // equal penetration and equal centres: both axes flip
        restartRun(160, 120, 10);
        runClks(4);
        checkVal("tie_vx", vx, 22);
        checkVal("tie_vy", vy, 22);
        checkVal("tie_y", y, 142);

        // touching edges are not a hit
        restartRun(140, 120, 10);
        runClks(4);
        checkVal("touch_collide", collide, 0);
        checkVal("touch_x", x, 140);
        checkVal("touch_hits", hit_count, 0);

        // top wall: clamp and reflect on the 5th tick
        restartRun(600, 400, 5);
        runClks(20);
        checkVal("wall_y", y, 25);
        checkVal("wall_vy", vy, 20);
        checkVal("wall_x", x, 60);

        // pause mid-divider freezes everything, resumes with the same phase
        restartRun(600, 400, 5);
        runClks(2);
        gamepause = 1;
        runClks(20);
        checkVal("pause_x", x, 160);
        gamepause = 0;
        runClks(1);
        checkVal("resume1_x", x, 160);
        runClks(1);
        checkVal("resume2_x", x, 140);

        // menu reloads start values mid-run
        runClks(9);
        gamemenu = 1; gamerun = 0;
        runClks(1);
        checkVal("menu_x", x, 160);
        checkVal("menu_vy", vy, -20);
        gamemenu = 0; gamerun = 1;

        // player covering the arena: hit every tick, saturations
        restartRun(320, 240, 400);
        runClks(1300);
`ifndef SPRITE_HIT_COOLDOWN_EN
        checkVal("hits_sat", hit_count, 255);
`endif
        checkVal("vx_sat", iabs(int'(vx)), 40);
        checkVal("vy_sat", iabs(int'(vy)), 40);

        // randomized traffic against the model
        restartRun(600, 400, 5);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    t = mX + int'($urandom_range(0, 50)) - 25;
                    aX = t[9:0];
                    t = mY + int'($urandom_range(0, 50)) - 25;
                    aY = t[9:0];
                end else begin
                    aX = 10'($urandom_range(0, 639));
                    aY = 10'($urandom_range(0, 479));
                end
                aR = 10'($urandom_range(0, 40));
            end
            if ($urandom_range(0, 24) == 0) begin
                sel = $urandom_range(0, 9);
                if (sel < 6) begin
                    gamemenu = 0; gamerun = 1; gamepause = 0;
                end else if (sel == 6) begin
                    gamemenu = 1; gamerun = 0; gamepause = 0;
                end else begin
                    {gamemenu, gamerun, gamepause} = 3'($urandom_range(0, 7));
                end
            end
            rst = ($urandom_range(0, 299) == 0);
            runClks(1);
        end

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
